keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotates one low column per scan tick,
// debounces presses and releases over DEBOUNCE_TICKS ticks, reports row*4+col.
module keypad_scanner #(
  parameter logic [7:0] DEBOUNCE_TICKS = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t     state_q, state_d;
  logic [3:0] row_s1_q, sync_row;
  logic       tick_in_q;
  logic       tick;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rel_cnt_q, rel_cnt_d;
  logic       any_low;
  logic [1:0] low_row;

  assign tick = scan_tick & ~tick_in_q;

  // Lowest-indexed low row wins when several keys in a column are down.
  always_comb begin
    any_low = (sync_row != 4'hF);
    if (!sync_row[0])      low_row = 2'd0;
    else if (!sync_row[1]) low_row = 2'd1;
    else if (!sync_row[2]) low_row = 2'd2;
    else                   low_row = 2'd3;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    cnt_d       = cnt_q;
    rel_cnt_d   = rel_cnt_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (!any_low) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d  = low_row;
            cand_d = {low_row, col_q};
            cnt_d  = 8'd1;
            if (DEBOUNCE_TICKS == 8'd1) begin
              key_code_d  = {low_row, col_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_cnt_d   = 8'd0;
              state_d     = PRESSED;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (any_low && (low_row == row_q)) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == DEBOUNCE_TICKS) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              rel_cnt_d   = 8'd0;
              state_d     = PRESSED;
            end
          end else begin
            cnt_d   = 8'd0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          // Only the captured row matters; other keys are ignored until release.
          if (!sync_row[row_q]) begin
            rel_cnt_d = 8'd0;
          end else begin
            rel_cnt_d = rel_cnt_q + 8'd1;
            if (rel_cnt_q + 8'd1 == DEBOUNCE_TICKS) begin
              key_held_d = 1'b0;
              col_d      = col_q + 2'd1;
              state_d    = SCAN;
            end
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q    <= 4'hF;
      sync_row    <= 4'hF;
      tick_in_q   <= 1'b1;
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      cnt_q       <= 8'd0;
      rel_cnt_q   <= 8'd0;
    end else begin
      row_s1_q    <= row_in;
      sync_row    <= row_s1_q;
      tick_in_q   <= scan_tick;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      cnt_q       <= cnt_d;
      rel_cnt_q   <= rel_cnt_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
